// File: rtl/lif_pkg.sv
// Shared defaults and arithmetic helpers for the adaptive-threshold LIF neuron array.
package lif_pkg;

  localparam int unsigned DEF_N_NEURONS  = 4;
  localparam int unsigned DEF_W          = 8;
  localparam int unsigned DEF_LEAK_SHIFT = 1;
  localparam int unsigned DEF_THRESHOLD  = 128;
  localparam int unsigned DEF_THR_INC    = 5;
  localparam int unsigned DEF_THR_DEC    = 1;
  localparam int unsigned DEF_THR_MIN    = 75;
  localparam int unsigned DEF_THR_MAX    = 250;
  localparam int unsigned DEF_REFRACTORY = 3;
  localparam int unsigned DEF_CNT_W      = 16;

  // Bits needed to hold a popcount of n flags.
  function automatic int unsigned pop_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // a + b computed one bit wider than the operands, clamped to lim.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

  // thr - dec, never dropping below floor_v; values already at/below the floor hold.
  function automatic logic [31:0] decay_floor(input logic [31:0] thr, input logic [31:0] dec,
                                              input logic [31:0] floor_v);
    if (thr <= floor_v) return thr;
    return ((thr - floor_v) >= dec) ? (thr - dec) : floor_v;
  endfunction

endpackage

// File: rtl/lif_array_neuron.sv
// One leaky integrate-and-fire neuron with adaptive threshold and refractory hold-off.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int unsigned W          = DEF_W,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
  parameter int unsigned THR_INC    = DEF_THR_INC,
  parameter int unsigned THR_DEC    = DEF_THR_DEC,
  parameter int unsigned THR_MIN    = DEF_THR_MIN,
  parameter int unsigned THR_MAX    = DEF_THR_MAX,
  parameter int unsigned REFRACTORY = DEF_REFRACTORY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] current,
  output logic         spike_next,
  output logic         spike,
  output logic [W-1:0] state,
  output logic [W-1:0] thr
);

  localparam int unsigned REFR_W   = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
  localparam logic [31:0] SAT_MAX  = (32'd1 << W) - 32'd1;

  logic [REFR_W-1:0] refr, refr_next;
  logic [W-1:0]      state_next, thr_next;
  logic [31:0]       sum_sat, thr_decayed;

  always_comb begin
    state_next  = state;
    thr_next    = thr;
    refr_next   = refr;
    spike_next  = 1'b0;
    sum_sat     = sat_add(32'(state >> LEAK_SHIFT), 32'(current), SAT_MAX);
    thr_decayed = decay_floor(32'(thr), THR_DEC, THR_MIN);
    if (en) begin
      if (refr != '0) begin
        // Refractory: input is ignored but the threshold still relaxes.
        state_next = '0;
        refr_next  = refr - REFR_W'(1);
        thr_next   = W'(thr_decayed);
      end else if (sum_sat >= 32'(thr)) begin
        spike_next = 1'b1;
        state_next = '0;
        refr_next  = REFR_W'(REFRACTORY);
        thr_next   = W'(sat_add(32'(thr), THR_INC, THR_MAX));
      end else begin
        state_next = W'(sum_sat);
        thr_next   = W'(thr_decayed);
      end
    end
  end

  // Stage boundary: registered neuron state, one step per enabled edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= '0;
      thr   <= W'(THRESHOLD);
      refr  <= '0;
      spike <= 1'b0;
    end else begin
      state <= state_next;
      thr   <= thr_next;
      refr  <= refr_next;
      spike <= spike_next;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Parallel array of adaptive LIF neurons with a shared, clearable spike counter.
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS  = DEF_N_NEURONS,
  parameter int unsigned W          = DEF_W,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
  parameter int unsigned THR_INC    = DEF_THR_INC,
  parameter int unsigned THR_DEC    = DEF_THR_DEC,
  parameter int unsigned THR_MIN    = DEF_THR_MIN,
  parameter int unsigned THR_MAX    = DEF_THR_MAX,
  parameter int unsigned REFRACTORY = DEF_REFRACTORY,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [N_NEURONS*W-1:0] current_i,
  input  logic                   cnt_clr_i,
  output logic [N_NEURONS-1:0]   spike_o,
  output logic [N_NEURONS*W-1:0] state_o,
  output logic [N_NEURONS*W-1:0] thr_o,
  output logic [CNT_W-1:0]       spike_cnt_o
);

  localparam int unsigned POP_W = pop_width(N_NEURONS);

  logic [N_NEURONS-1:0] spike_next;
  logic [POP_W-1:0]     pop;

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
    lif_neuron #(
      .W(W), .LEAK_SHIFT(LEAK_SHIFT), .THRESHOLD(THRESHOLD), .THR_INC(THR_INC),
      .THR_DEC(THR_DEC), .THR_MIN(THR_MIN), .THR_MAX(THR_MAX), .REFRACTORY(REFRACTORY)
    ) u_neuron (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .en         (en_i),
      .current    (current_i[i*W +: W]),
      .spike_next (spike_next[i]),
      .spike      (spike_o[i]),
      .state      (state_o[i*W +: W]),
      .thr        (thr_o[i*W +: W])
    );
  end

  // Count the spikes being registered this edge so the counter tracks spike_o exactly.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_NEURONS; i++) pop = pop + POP_W'(spike_next[i]);
  end

  // Stage boundary: spike counter; clear reloads with this edge's spikes so none are lost.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)        spike_cnt_o <= '0;
    else if (cnt_clr_i) spike_cnt_o <= CNT_W'(pop);
    else                spike_cnt_o <= spike_cnt_o + CNT_W'(pop);
  end

endmodule

// File: tb/tb_lif_array.sv
// Directed + random bench for lif_array: scoreboard model on a default instance, constants on variants.
module tb_lif_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, clr_a, en_b, clr_b, en_c, clr_c;
  logic [31:0] cur_a, cur_b, cur_c;
  logic [3:0]  spike_a, spike_b, spike_c;
  logic [31:0] state_a, state_b, state_c, thr_a, thr_b, thr_c;
  logic [15:0] cnt_a, cnt_c;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  spike;
    logic [31:0] state;
    logic [31:0] thr;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   m_state[4], m_thr[4], m_refr[4];
  int   m_cnt;

  always #5 clk = ~clk;

  lif_array dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_a), .current_i(cur_a), .cnt_clr_i(clr_a),
    .spike_o(spike_a), .state_o(state_a), .thr_o(thr_a), .spike_cnt_o(cnt_a)
  );

  lif_array #(.REFRACTORY(0), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .current_i(cur_b), .cnt_clr_i(clr_b),
    .spike_o(spike_b), .state_o(state_b), .thr_o(thr_b), .spike_cnt_o(cnt_b)
  );

  lif_array #(.THRESHOLD(250), .THR_MIN(250), .THR_MAX(250)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_c), .current_i(cur_c), .cnt_clr_i(clr_c),
    .spike_o(spike_c), .state_o(state_c), .thr_o(thr_c), .spike_cnt_o(cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int relax(input int t);
    if (t <= 75) return t;
    return (t - 1 < 75) ? 75 : t - 1;
  endfunction

  // Reference behaviour of the default-parameter array; pushes the expected post-edge outputs.
  task automatic model_step(input logic [31:0] cur, input logic en, input logic clr,
                            input logic rstn);
    exp_t e;
    int   s;
    int   pc;
    pc      = 0;
    e.spike = '0;
    e.state = '0;
    e.thr   = '0;
    for (int i = 0; i < 4; i++) begin
      if (!rstn) begin
        m_state[i] = 0; m_thr[i] = 128; m_refr[i] = 0;
      end else if (en) begin
        if (m_refr[i] > 0) begin
          m_state[i] = 0;
          m_refr[i]  = m_refr[i] - 1;
          m_thr[i]   = relax(m_thr[i]);
        end else begin
          s = (m_state[i] / 2) + int'(cur[i*8 +: 8]);
          if (s > 255) s = 255;
          if (s >= m_thr[i]) begin
            e.spike[i] = 1'b1;
            pc++;
            m_state[i] = 0;
            m_refr[i]  = 3;
            m_thr[i]   = (m_thr[i] + 5 > 250) ? 250 : m_thr[i] + 5;
          end else begin
            m_state[i] = s;
            m_thr[i]   = relax(m_thr[i]);
          end
        end
      end
      e.state[i*8 +: 8] = 8'(m_state[i]);
      e.thr[i*8 +: 8]   = 8'(m_thr[i]);
    end
    if (!rstn)    m_cnt = 0;
    else if (clr) m_cnt = pc;
    else          m_cnt = (m_cnt + pc) % 65536;
    e.cnt = 16'(m_cnt);
    sb.push_back(e);
  endtask

  // Drive one clock of stimulus on dut_a (and the shared reset), then score dut_a's outputs.
  task automatic step(input logic [31:0] cur, input logic en, input logic clr, input logic rstn);
    exp_t e;
    cur_a = cur; en_a = en; clr_a = clr; rst_n = rstn;
    model_step(cur, en, clr, rstn);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check("a_spike", 32'(spike_a), 32'(e.spike));
      check("a_state", state_a, e.state);
      check("a_thr",   thr_a,   e.thr);
      check("a_cnt",   32'(cnt_a), 32'(e.cnt));
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_thr;
    logic [31:0] rc;
    logic        re, rclr;
    rst_n = 1'b0;
    en_a = 1'b1; clr_a = 1'b0; cur_a = '0;
    en_b = 1'b1; clr_b = 1'b0; cur_b = '0;
    en_c = 1'b1; clr_c = 1'b0; cur_c = '0;
    @(negedge clk);

    // Reset state.
    step(32'd0, 1'b1, 1'b0, 1'b0);
    step(32'd0, 1'b1, 1'b1, 1'b0);
    check("rst_b_thr", thr_b, 32'h80808080);
    check("rst_c_thr", thr_c, 32'hFAFAFAFA);
    check("rst_b_cnt", 32'(cnt_b), 32'd0);

    // No refractory, max current: spike every step, threshold climbs to the ceiling.
    cur_b = 32'h000000FF;
    for (int k = 1; k <= 27; k++) begin
      step(32'd0, 1'b1, 1'b0, 1'b1);
      exp_thr = (128 + 5 * k > 250) ? 250 : 128 + 5 * k;
      check("b_spike_every_step", 32'(spike_b[0]), 32'd1);
      check("b_thr_climb", 32'(thr_b[7:0]), 32'(exp_thr));
    end
    check("b_cnt_27", 32'(cnt_b), 32'd11);

    // Counter wrap at CNT_W=4: 4,8,12,14 then +4 -> 2.
    step(32'd0, 1'b1, 1'b0, 1'b0);
    cur_b = 32'hFFFFFFFF;
    for (int k = 1; k <= 3; k++) begin
      step(32'd0, 1'b1, 1'b0, 1'b1);
      check("b_cnt_acc", 32'(cnt_b), 32'(4 * k));
    end
    cur_b = 32'h0000FFFF;
    step(32'd0, 1'b1, 1'b0, 1'b1);
    check("b_cnt_14", 32'(cnt_b), 32'd14);
    cur_b = 32'hFFFFFFFF;
    step(32'd0, 1'b1, 1'b0, 1'b1);
    check("b_spike_all", 32'(spike_b), 32'hF);
    check("b_cnt_wrap", 32'(cnt_b), 32'd2);
    cur_b = '0;

    // Saturating integration: 100 + 255 clamps to 255, which reaches thr=250.
    step(32'd0, 1'b1, 1'b0, 1'b0);
    cur_c = 32'd200;
    step(32'd0, 1'b1, 1'b0, 1'b1);
    check("c_state_200", 32'(state_c[7:0]), 32'd200);
    check("c_no_spike", 32'(spike_c[0]), 32'd0);
    cur_c = 32'd255;
    step(32'd0, 1'b1, 1'b0, 1'b1);
    check("c_sat_spike", 32'(spike_c[0]), 32'd1);
    check("c_thr_ceiling", 32'(thr_c[7:0]), 32'd250);
    cur_c = '0;

    // Neuron 0 with constant current 100.
    step(32'd0, 1'b1, 1'b0, 1'b0);
    step(32'd100, 1'b1, 1'b0, 1'b1);
    check("t1_e1_state", 32'(state_a[7:0]), 32'd100);
    check("t1_e1_thr", 32'(thr_a[7:0]), 32'd127);
    step(32'd100, 1'b1, 1'b0, 1'b1);
    check("t1_e2_spike", 32'(spike_a[0]), 32'd1);
    check("t1_e2_thr", 32'(thr_a[7:0]), 32'd132);
    for (int k = 0; k < 3; k++) begin
      step(32'd100, 1'b1, 1'b0, 1'b1);
      check("t1_refr_state", 32'(state_a[7:0]), 32'd0);
      check("t1_refr_thr", 32'(thr_a[7:0]), 32'(131 - k));
    end
    step(32'd100, 1'b1, 1'b0, 1'b1);
    check("t1_e6_state", 32'(state_a[7:0]), 32'd100);

    // Zero input: threshold relaxes to the floor and holds there.
    step(32'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      step(32'd0, 1'b1, 1'b0, 1'b1);
      if (k == 53) check("t2_floor_at_53", 32'(thr_a[7:0]), 32'd75);
    end
    check("t2_floor_hold", 32'(thr_a[7:0]), 32'd75);
    check("t2_no_spikes", 32'(cnt_a), 32'd0);

    // Freeze mid-refractory, resume, then reset mid-refractory.
    step(32'd0, 1'b1, 1'b0, 1'b0);
    step(32'd100, 1'b1, 1'b0, 1'b1);
    step(32'd100, 1'b1, 1'b0, 1'b1);
    step(32'd100, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step(32'd100, 1'b0, 1'b0, 1'b1);
    check("t5_frozen_thr", 32'(thr_a[7:0]), 32'd131);
    check("t5_frozen_spike", 32'(spike_a), 32'd0);
    step(32'd100, 1'b1, 1'b0, 1'b1);
    step(32'd100, 1'b1, 1'b0, 1'b1);
    check("t5_resume_thr", 32'(thr_a[7:0]), 32'd129);
    step(32'd100, 1'b1, 1'b0, 1'b1);
    check("t5_resume_state", 32'(state_a[7:0]), 32'd100);
    step(32'd100, 1'b1, 1'b0, 1'b1);
    check("t5_spike_again", 32'(spike_a[0]), 32'd1);
    step(32'd100, 1'b1, 1'b0, 1'b1);
    step(32'd100, 1'b1, 1'b1, 1'b0);
    check("t5_rst_thr", 32'(thr_a[7:0]), 32'd128);
    step(32'd100, 1'b1, 1'b0, 1'b1);
    check("t5_refr_cleared", 32'(state_a[7:0]), 32'd100);

    // All neurons spike on the edge that clears the counter.
    step(32'd0, 1'b1, 1'b0, 1'b0);
    step(32'hC8C8C8C8, 1'b1, 1'b0, 1'b1);
    check("t6_cnt_first", 32'(cnt_a), 32'd4);
    for (int k = 0; k < 3; k++) step(32'd0, 1'b1, 1'b0, 1'b1);
    step(32'hC8C8C8C8, 1'b1, 1'b1, 1'b1);
    check("t6_spike_all", 32'(spike_a), 32'hF);
    check("t6_clr_keeps_new", 32'(cnt_a), 32'd4);
    step(32'd0, 1'b1, 1'b1, 1'b1);

    // Random mix of currents, enables and clears.
    for (int k = 0; k < 80; k++) begin
      rc   = $urandom;
      re   = ($urandom_range(0, 3) != 0);
      rclr = re && ($urandom_range(0, 7) == 0);
      step(rc, re, rclr, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
